// File: rtl/noc_req_scheduler_if.sv
// rtl/noc_req_scheduler_if.sv - requester/memory/response handshake bundle for noc_req_scheduler
interface noc_req_scheduler_if #(
  parameter int RADIX   = 4,
  parameter int MAX_OUT = 4
);
  localparam int TAG_W = ($clog2(RADIX) > 1) ? $clog2(RADIX) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [RADIX-1:0] req_valid;
  logic [RADIX-1:0] req_ready;
  logic             mem_valid;
  logic             mem_ready;
  logic [TAG_W-1:0] grant_id;
  logic             rsp_valid;
  logic [TAG_W-1:0] rsp_tag;
  logic [RADIX-1:0] rsp_en;
  logic [CNT_W-1:0] outstanding;
  logic             err;

  modport master (
    output req_valid, mem_ready, rsp_valid, rsp_tag,
    input  req_ready, mem_valid, grant_id, rsp_en, outstanding, err
  );

  modport slave (
    input  req_valid, mem_ready, rsp_valid, rsp_tag,
    output req_ready, mem_valid, grant_id, rsp_en, outstanding, err
  );
endinterface

// File: rtl/noc_req_scheduler.sv
// rtl/noc_req_scheduler.sv - round-robin request scheduler with outstanding-transaction limit
// Optional per-requester grant counters enabled by NOC_SCHED_PERF_EN.
module noc_req_scheduler #(
  parameter int RADIX   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic clk,
  input  logic rst_l,
  noc_req_scheduler_if.slave bus
`ifdef NOC_SCHED_PERF_EN
  ,
  output logic [RADIX-1:0][15:0] grant_cnt
`endif
);
  localparam int TAG_W = ($clog2(RADIX) > 1) ? $clog2(RADIX) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [TAG_W-1:0] LAST_ID = TAG_W'(RADIX - 1);
  localparam logic [TAG_W:0]   RADIX_T = (TAG_W + 1)'(RADIX);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, ISSUE, FULL} state_e;

  state_e           state_q, state_d;
  logic [TAG_W-1:0] grant_q, grant_d;
  logic [TAG_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic                 win_found;
  logic [TAG_W-1:0]     win_idx;
  logic [TAG_W:0]       win_sum;
  logic [2*RADIX-1:0]   req_rot;
  logic                 issue;
  logic                 tag_ok;
  logic                 rsp_ok;

  // Rotate so bit 0 is the requester at rr_q; the first set bit wins.
  always_comb begin
    req_rot   = {bus.req_valid, bus.req_valid} >> rr_q;
    win_found = 1'b0;
    win_idx   = '0;
    win_sum   = '0;
    for (int i = 0; i < RADIX; i++) begin
      if (!win_found && req_rot[i]) begin
        win_found = 1'b1;
        win_sum   = {1'b0, rr_q} + (TAG_W + 1)'(i);
        if (win_sum >= RADIX_T) win_sum = win_sum - RADIX_T;
        win_idx   = win_sum[TAG_W-1:0];
      end
    end
  end

  assign issue  = (state_q == ISSUE) && bus.mem_ready && rst_l;
  assign tag_ok = ({1'b0, bus.rsp_tag} < RADIX_T);
  assign rsp_ok = bus.rsp_valid && tag_ok && (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (bus.rsp_valid && (!tag_ok || (cnt_q == '0)));
    case ({issue, rsp_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (issue) rr_d = (grant_q == LAST_ID) ? '0 : grant_q + TAG_W'(1);
    case (state_q)
      IDLE: begin
        if ((cnt_q < MAX_CNT) && win_found) begin
          grant_d = win_idx;
          state_d = ISSUE;
        end else if (cnt_q == MAX_CNT) begin
          state_d = FULL;
        end
      end
      ISSUE:   if (bus.mem_ready) state_d = IDLE;
      FULL:    if (cnt_d < MAX_CNT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_valid   = (state_q == ISSUE) && rst_l;
    bus.req_ready   = issue ? (RADIX'(1) << grant_q) : '0;
    bus.rsp_en      = (bus.rsp_valid && tag_ok) ? (RADIX'(1) << bus.rsp_tag) : '0;
    bus.grant_id    = grant_q;
    bus.outstanding = cnt_q;
    bus.err         = err_q;
  end

`ifdef NOC_SCHED_PERF_EN
  logic [RADIX-1:0][15:0] gcnt_q, gcnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    if (issue && (gcnt_q[grant_q] != 16'hFFFF)) gcnt_d[grant_q] = gcnt_q[grant_q] + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) gcnt_q <= '0;
    else        gcnt_q <= gcnt_d;
  end

  assign grant_cnt = gcnt_q;
`endif
endmodule

// File: tb/tb_noc_req_scheduler.sv
// tb/tb_noc_req_scheduler.sv - directed self-checking bench for noc_req_scheduler
module tb_noc_req_scheduler;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  noc_req_scheduler_if #(.RADIX(4), .MAX_OUT(4)) bus ();
  noc_req_scheduler_if #(.RADIX(3), .MAX_OUT(4)) bus3 ();

`ifdef NOC_SCHED_PERF_EN
  logic [3:0][15:0] grant_cnt;
  logic [2:0][15:0] grant_cnt3;
`endif

  noc_req_scheduler #(.RADIX(4), .MAX_OUT(4)) dut (
    .clk(clk), .rst_l(rst_l), .bus(bus)
`ifdef NOC_SCHED_PERF_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  noc_req_scheduler #(.RADIX(3), .MAX_OUT(4)) dut3 (
    .clk(clk), .rst_l(rst_l), .bus(bus3)
`ifdef NOC_SCHED_PERF_EN
    , .grant_cnt(grant_cnt3)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0; bus.mem_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_tag = '0;
    bus3.req_valid = '0; bus3.mem_ready = 1'b0; bus3.rsp_valid = 1'b0; bus3.rsp_tag = '0;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    clear_inputs();
    bus.req_valid = 4'b1111; bus.mem_ready = 1'b1;
    bus.rsp_valid = 1'b1; bus.rsp_tag = 2'd2;
    for (int r = 0; r < 2; r++) begin
      cyc();
      total++; if (bus.mem_valid !== 1'b0) $display("FAIL rst_mem_valid got %0b exp 0", bus.mem_valid); else passed++;
      total++; if (bus.req_ready !== 4'b0000) $display("FAIL rst_req_ready got %b exp 0000", bus.req_ready); else passed++;
      total++; if (bus.outstanding !== 3'd0) $display("FAIL rst_outstanding got %0d exp 0", bus.outstanding); else passed++;
      total++; if (bus.err !== 1'b0) $display("FAIL rst_err got %0b exp 0", bus.err); else passed++;
      total++; if (bus.grant_id !== 2'd0) $display("FAIL rst_grant_id got %0d exp 0", bus.grant_id); else passed++;
      total++; if (bus.rsp_en !== 4'b0100) $display("FAIL rst_rsp_en got %b exp 0100", bus.rsp_en); else passed++;
      total++; if (bus3.outstanding !== 3'd0) $display("FAIL rst3_outstanding got %0d exp 0", bus3.outstanding); else passed++;
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [5];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    bus.req_valid = 4'b1111; bus.mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc();
      bus.rsp_valid = (k >= 2) && (k % 2 == 0);
      if (k >= 2 && k % 2 == 0) bus.rsp_tag = seq[k/2 - 1];
      #1;
      total++; if (bus.mem_valid !== 1'(k % 2)) $display("FAIL rr_mem_valid k=%0d got %0b exp %0b", k, bus.mem_valid, 1'(k % 2)); else passed++;
      total++; if (bus.outstanding !== ((k >= 2 && k % 2 == 0) ? 3'd1 : 3'd0)) $display("FAIL rr_outstanding k=%0d got %0d", k, bus.outstanding); else passed++;
      if (k % 2 == 1) begin
        total++; if (bus.grant_id !== seq[k/2]) $display("FAIL rr_grant_id k=%0d got %0d exp %0d", k, bus.grant_id, seq[k/2]); else passed++;
        total++; if (bus.req_ready !== (4'b0001 << seq[k/2])) $display("FAIL rr_req_ready k=%0d got %b exp %b", k, bus.req_ready, 4'b0001 << seq[k/2]); else passed++;
      end
    end
    cyc();
    bus.req_valid = '0; bus.mem_ready = 1'b0;
    total++; if (bus.outstanding !== 3'd1) $display("FAIL rr_final_outstanding got %0d exp 1", bus.outstanding); else passed++;
    total++; if (bus.err !== 1'b0) $display("FAIL rr_err got %0b exp 0", bus.err); else passed++;
`ifdef NOC_SCHED_PERF_EN
    total++; if (grant_cnt !== {16'd1, 16'd1, 16'd1, 16'd2}) $display("FAIL rr_grant_cnt got %h exp 0001000100010002", grant_cnt); else passed++;
`endif
  endtask

  task automatic test_stall();
    do_reset();
    bus.req_valid = 4'b0100; bus.mem_ready = 1'b0;
    #1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 3) bus.req_valid = 4'b0101;
      #1;
      total++; if (bus.mem_valid !== 1'b1) $display("FAIL stall_mem_valid k=%0d got %0b exp 1", k, bus.mem_valid); else passed++;
      total++; if (bus.grant_id !== 2'd2) $display("FAIL stall_grant_id k=%0d got %0d exp 2", k, bus.grant_id); else passed++;
      total++; if (bus.req_ready !== 4'b0000) $display("FAIL stall_req_ready k=%0d got %b exp 0000", k, bus.req_ready); else passed++;
    end
    cyc();
    bus.mem_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 4'b0100) $display("FAIL stall_accept got %b exp 0100", bus.req_ready); else passed++;
    cyc();
    bus.req_valid = '0; bus.mem_ready = 1'b0;
    #1;
    total++; if (bus.outstanding !== 3'd1) $display("FAIL stall_outstanding got %0d exp 1", bus.outstanding); else passed++;
    total++; if (bus.req_ready !== 4'b0000) $display("FAIL stall_ready_drop got %b exp 0000", bus.req_ready); else passed++;
  endtask

  task automatic test_full();
    do_reset();
    bus.req_valid = 4'b1111; bus.mem_ready = 1'b1;
    #1;
    for (int k = 1; k <= 8; k++) cyc();
    total++; if (bus.outstanding !== 3'd4) $display("FAIL full_outstanding got %0d exp 4", bus.outstanding); else passed++;
    for (int k = 9; k <= 10; k++) begin
      cyc();
      total++; if (bus.mem_valid !== 1'b0) $display("FAIL full_mem_valid k=%0d got %0b exp 0", k, bus.mem_valid); else passed++;
    end
    cyc();
    bus.rsp_valid = 1'b1; bus.rsp_tag = 2'd1;
    #1;
    total++; if (bus.rsp_en !== 4'b0010) $display("FAIL full_rsp_en got %b exp 0010", bus.rsp_en); else passed++;
    cyc();
    bus.rsp_valid = 1'b0;
    #1;
    total++; if (bus.outstanding !== 3'd3) $display("FAIL full_drain got %0d exp 3", bus.outstanding); else passed++;
    total++; if (bus.mem_valid !== 1'b0) $display("FAIL full_idle_mem_valid got %0b exp 0", bus.mem_valid); else passed++;
    cyc();
    total++; if (bus.mem_valid !== 1'b1) $display("FAIL full_reissue got %0b exp 1", bus.mem_valid); else passed++;
    total++; if (bus.grant_id !== 2'd0) $display("FAIL full_reissue_grant got %0d exp 0", bus.grant_id); else passed++;
    cyc();
    bus.req_valid = '0; bus.mem_ready = 1'b0;
    total++; if (bus.outstanding !== 3'd4) $display("FAIL full_refill got %0d exp 4", bus.outstanding); else passed++;
  endtask

  task automatic test_issue_with_rsp();
    do_reset();
    bus.req_valid = 4'b0011; bus.mem_ready = 1'b1;
    #1;
    for (int k = 1; k <= 4; k++) cyc();
    total++; if (bus.outstanding !== 3'd2) $display("FAIL iwr_pre got %0d exp 2", bus.outstanding); else passed++;
    cyc();
    bus.rsp_valid = 1'b1; bus.rsp_tag = 2'd1;
    #1;
    total++; if (bus.grant_id !== 2'd0) $display("FAIL iwr_grant got %0d exp 0", bus.grant_id); else passed++;
    total++; if (bus.req_ready !== 4'b0001) $display("FAIL iwr_req_ready got %b exp 0001", bus.req_ready); else passed++;
    total++; if (bus.rsp_en !== 4'b0010) $display("FAIL iwr_rsp_en got %b exp 0010", bus.rsp_en); else passed++;
    cyc();
    bus.rsp_valid = 1'b0; bus.req_valid = '0; bus.mem_ready = 1'b0;
    #1;
    total++; if (bus.outstanding !== 3'd2) $display("FAIL iwr_post got %0d exp 2", bus.outstanding); else passed++;
    total++; if (bus.err !== 1'b0) $display("FAIL iwr_err got %0b exp 0", bus.err); else passed++;
  endtask

  task automatic test_err();
    do_reset();
    bus.rsp_valid = 1'b1; bus.rsp_tag = 2'd0;
    bus3.rsp_valid = 1'b1; bus3.rsp_tag = 2'd3;
    #1;
    total++; if (bus.rsp_en !== 4'b0001) $display("FAIL err_rsp_en got %b exp 0001", bus.rsp_en); else passed++;
    total++; if (bus3.rsp_en !== 3'b000) $display("FAIL err3_rsp_en_bad_tag got %b exp 000", bus3.rsp_en); else passed++;
    cyc();
    bus.rsp_valid = 1'b0; bus3.rsp_tag = 2'd2;
    #1;
    total++; if (bus.err !== 1'b1) $display("FAIL err_set got %0b exp 1", bus.err); else passed++;
    total++; if (bus.outstanding !== 3'd0) $display("FAIL err_outstanding got %0d exp 0", bus.outstanding); else passed++;
    total++; if (bus3.err !== 1'b1) $display("FAIL err3_set got %0b exp 1", bus3.err); else passed++;
    total++; if (bus3.outstanding !== 3'd0) $display("FAIL err3_outstanding got %0d exp 0", bus3.outstanding); else passed++;
    total++; if (bus3.rsp_en !== 3'b100) $display("FAIL err3_rsp_en got %b exp 100", bus3.rsp_en); else passed++;
    bus3.rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    total++; if (bus.err !== 1'b1) $display("FAIL err_sticky got %0b exp 1", bus.err); else passed++;
    do_reset();
    #1;
    total++; if (bus.err !== 1'b0) $display("FAIL err_clear got %0b exp 0", bus.err); else passed++;
    total++; if (bus3.err !== 1'b0) $display("FAIL err3_clear got %0b exp 0", bus3.err); else passed++;
  endtask

  task automatic test_reset_in_issue();
    do_reset();
    bus.req_valid = 4'b0010; bus.mem_ready = 1'b1;
    #1;
    cyc();
    total++; if (bus.req_ready !== 4'b0010) $display("FAIL rii_first_accept got %b exp 0010", bus.req_ready); else passed++;
    cyc();
    bus.req_valid = 4'b1001; bus.mem_ready = 1'b0;
    #1;
    total++; if (bus.outstanding !== 3'd1) $display("FAIL rii_outstanding got %0d exp 1", bus.outstanding); else passed++;
    cyc();
    total++; if (bus.grant_id !== 2'd3) $display("FAIL rii_grant got %0d exp 3", bus.grant_id); else passed++;
    total++; if (bus.mem_valid !== 1'b1) $display("FAIL rii_in_issue got %0b exp 1", bus.mem_valid); else passed++;
    cyc();
    rst_l = 1'b0; bus.mem_ready = 1'b1;
    #1;
    total++; if (bus.mem_valid !== 1'b0) $display("FAIL rii_rst_mem_valid got %0b exp 0", bus.mem_valid); else passed++;
    total++; if (bus.req_ready !== 4'b0000) $display("FAIL rii_rst_req_ready got %b exp 0000", bus.req_ready); else passed++;
    cyc();
    rst_l = 1'b1; bus.mem_ready = 1'b0;
    #1;
    total++; if (bus.mem_valid !== 1'b0) $display("FAIL rii_post_mem_valid got %0b exp 0", bus.mem_valid); else passed++;
    total++; if (bus.outstanding !== 3'd0) $display("FAIL rii_post_outstanding got %0d exp 0", bus.outstanding); else passed++;
`ifdef NOC_SCHED_PERF_EN
    total++; if (grant_cnt !== '0) $display("FAIL rii_grant_cnt got %h exp 0", grant_cnt); else passed++;
`endif
    cyc();
    total++; if (bus.mem_valid !== 1'b1) $display("FAIL rii_restart_mem_valid got %0b exp 1", bus.mem_valid); else passed++;
    total++; if (bus.grant_id !== 2'd0) $display("FAIL rii_restart_grant got %0d exp 0", bus.grant_id); else passed++;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_stall();
    test_full();
    test_issue_with_rsp();
    test_err();
    test_reset_in_issue();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/noc_req_scheduler.md
NOC_REQ_SCHEDULER -- requirements
Module: noc_req_scheduler

Interface
REQ-001 Parameter RADIX, default 4: number of requester ports; legal range 2..16.
REQ-002 Parameter MAX_OUT, default 4: maximum outstanding memory transactions; legal range 1..15.
REQ-003 Derived widths: TAG_W = max(1, $clog2(RADIX)); CNT_W = $clog2(MAX_OUT+1).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_l  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  RADIX  per-requester request pending.
REQ-007 req_ready  output  RADIX  one-hot accept pulse to the granted requester.
REQ-008 mem_valid  output  1  request presented to the memory port.
REQ-009 mem_ready  input  1  memory port accepts the request.
REQ-010 grant_id  output  TAG_W  index of the requester currently presented; it drives the datapath mux select and travels as the transaction tag.
REQ-011 rsp_valid  input  1  memory response present.
REQ-012 rsp_tag  input  TAG_W  requester index carried by the response.
REQ-013 rsp_en  output  RADIX  one-hot response enable to requester rsp_tag; drives the demux select.
REQ-014 outstanding  output  CNT_W  count of issued transactions with no response yet.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and FULL.
REQ-017 IDLE: if outstanding < MAX_OUT and any req_valid is set, the block SHALL register the winner into grant_id and go to ISSUE; if outstanding == MAX_OUT, it SHALL go to FULL; otherwise it SHALL stay in IDLE.
REQ-018 Winner selection SHALL be round-robin: the first set req_valid bit at or above rr_ptr, wrapping from RADIX-1 to 0.
REQ-019 ISSUE: mem_valid SHALL be 1, and grant_id SHALL hold stable until the cycle in which mem_ready=1.
REQ-020 In that mem_ready cycle, req_ready[grant_id] SHALL be 1 combinationally; all other req_ready bits SHALL be 0 at all times.
REQ-021 On the mem_valid & mem_ready edge: outstanding SHALL increment, rr_ptr SHALL become (grant_id+1) mod RADIX, and the next state SHALL be IDLE.
REQ-022 Throughput SHALL be at most one issue per two cycles; arbitration-to-mem_valid latency SHALL be one cycle.
REQ-023 Once granted, a request SHALL be committed: ISSUE SHALL ignore req_valid. Requesters hold req_valid until req_ready.
REQ-024 FULL: mem_valid SHALL be 0; the block SHALL return to IDLE on the edge where outstanding drops below MAX_OUT.
REQ-025 rsp_en SHALL equal one-hot(rsp_tag) when rsp_valid=1, else 0; this path is combinational with zero latency.
REQ-026 A valid response SHALL decrement outstanding.
REQ-027 An issue and a response in the same cycle SHALL leave outstanding unchanged.
REQ-028 Response with outstanding == 0: outstanding SHALL stay 0 and err SHALL set.
REQ-029 Response with rsp_tag >= RADIX: rsp_en SHALL be 0, outstanding SHALL be unchanged, and err SHALL set.
REQ-030 outstanding SHALL never exceed MAX_OUT or wrap.

Reset
REQ-031 While rst_l=0 at a clock edge, the block SHALL load: state=IDLE, rr_ptr=0, grant_id=0, outstanding=0, err=0.
REQ-032 During reset, mem_valid SHALL be 0 and req_ready SHALL be 0; rsp_en SHALL still follow REQ-025.
REQ-033 A reset asserted in ISSUE or FULL SHALL abandon the pending grant and drop all outstanding-count state; no req_ready pulse SHALL be issued for the abandoned grant.

Configuration
REQ-034 Macro NOC_SCHED_PERF_EN, when defined, SHALL add output grant_cnt [RADIX][16].
REQ-035 grant_cnt SHALL hold a per-requester count of accepted issues; each counter SHALL saturate at 16'hFFFF and clear on reset.
REQ-036 When NOC_SCHED_PERF_EN is undefined, the grant_cnt port and its counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-037 Reset, then req_valid=4'b1111 with mem_ready=1 held high -> grant_id sequence 0,1,2,3,0, with mem_valid high every second cycle.
REQ-038 req_valid=4'b0100 with mem_ready=0 for 5 cycles -> mem_valid=1 and grant_id=2 stable for all 5 cycles, req_ready=0; then mem_ready=1 -> req_ready=4'b0100 for one cycle and outstanding=1.
REQ-039 MAX_OUT=4, four issues with no responses -> state FULL and mem_valid=0; one rsp_valid with rsp_tag=1 -> rsp_en=4'b0010 in the same cycle, outstanding=3, next issue two cycles later.
REQ-040 Issue accepted in the same cycle as rsp_valid (outstanding=2) -> outstanding remains 2.
REQ-041 rsp_valid with outstanding=0 -> err=1 and sticky until reset, outstanding=0; a separate run with RADIX=3 and rsp_tag=3 -> rsp_en=0 and err=1.
REQ-042 rst_l=0 for one edge while in ISSUE -> next cycle mem_valid=0, outstanding=0, and the next grant starts from requester 0; with NOC_SCHED_PERF_EN defined, grant_cnt all 0.
